// File: rtl/alu_seq_shifter_pkg.sv
// Shared definitions for the ALU32 sequential shift unit.
// Contents: default operand/shift-amount widths, op codes, FSM state codes.
// Optional feature macro used by the unit: ALU_SHIFT_FAST4_EN.
package alu_seq_shifter_pkg;

  localparam int unsigned ALU_N       = 32;
  localparam int unsigned ALU_SHAMT_W = 5;

  // Shift operation select.
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } alu_shift_op_e;

  // Sequencer state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_shift_state_e;

endpackage

// File: rtl/alu_seq_shifter_if.sv
// Request/response bundle of the sequential shift unit.
// master: drives start/op/a/shamt, observes busy/done/result.
// slave : the shift unit itself.
interface alu_seq_shifter_if
  import alu_seq_shifter_pkg::*;
#(
  parameter int unsigned N       = ALU_N,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) ();

  logic               start;
  alu_shift_op_e      op;
  logic [N-1:0]       a;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [N-1:0]       result;

  modport master (output start, op, a, shamt, input busy, done, result);
  modport slave  (input start, op, a, shamt, output busy, done, result);

endinterface

// File: rtl/alu_seq_shifter_shift_step.sv
// shift_step: combinational shift of DIST positions selected by op.
// Ports: op_i (operation), data_i (value to shift), data_c_o (shifted value, combinational).
module shift_step
  import alu_seq_shifter_pkg::*;
#(
  parameter int unsigned N    = ALU_N,
  parameter int unsigned DIST = 1
) (
  input  alu_shift_op_e op_i,
  input  logic [N-1:0]  data_i,
  output logic [N-1:0]  data_c_o
);

  // One shift of DIST bits; PASS leaves the value untouched.
  always_comb begin
    data_c_o = data_i;
    case (op_i)
      OP_SLL:  data_c_o = {data_i[N-1-DIST:0], {DIST{1'b0}}};
      OP_SRL:  data_c_o = {{DIST{1'b0}}, data_i[N-1:DIST]};
      OP_SRA:  data_c_o = {{DIST{data_i[N-1]}}, data_i[N-1:DIST]};
      OP_PASS: data_c_o = data_i;
      default: data_c_o = data_i;
    endcase
  end

endmodule

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: multi-cycle SLL/SRL/SRA unit, one bit per clock under a
// start/busy/done handshake; result feeds the ALU result mux.
// Ports: clk (rising edge), rst (synchronous, active high),
//        bus (alu_seq_shifter_if.slave: start/op/a/shamt in, busy/done/result out).
// Macro ALU_SHIFT_FAST4_EN: while 4 or more positions remain, step by 4 per clock.
module alu_seq_shifter
  import alu_seq_shifter_pkg::*;
#(
  parameter int unsigned N       = ALU_N,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input logic              clk,
  input logic              rst,
  alu_seq_shifter_if.slave bus
);

  alu_shift_state_e   state_q, state_d;
  alu_shift_op_e      op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [N-1:0]       result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N-1:0]       step1_c;

  shift_step #(.N(N), .DIST(1)) u_step1 (
    .op_i     (op_q),
    .data_i   (result_q),
    .data_c_o (step1_c)
  );

`ifdef ALU_SHIFT_FAST4_EN
  logic [N-1:0] step4_c;

  shift_step #(.N(N), .DIST(4)) u_step4 (
    .op_i     (op_q),
    .data_i   (result_q),
    .data_c_o (step4_c)
  );
`endif

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          result_d = bus.a;
          op_d     = bus.op;
          count_d  = bus.shamt;
          if ((bus.shamt == '0) || (bus.op == OP_PASS)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
`ifdef ALU_SHIFT_FAST4_EN
        if (count_q >= SHAMT_W'(4)) begin
          result_d = step4_c;
          count_d  = count_q - SHAMT_W'(4);
        end else
`endif
        begin
          result_d = step1_c;
          count_d  = count_q - SHAMT_W'(1);
        end
        // Finish on the step that consumes the last position.
        if (count_d == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Directed, table-driven bench for alu_seq_shifter (either step mode).
module tb_alu_seq_shifter;
  import alu_seq_shifter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_seq_shifter_if bus ();

  alu_seq_shifter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_shift_op_e op;
    logic [31:0]   a;
    logic [4:0]    shamt;
    logic [31:0]   exp_result;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycles from the accepting edge (counted as 1) to done.
  function automatic int exp_lat(input alu_shift_op_e op, input int s);
    if (op == OP_PASS || s == 0) return 1;
`ifdef ALU_SHIFT_FAST4_EN
    return (s >> 2) + (s & 3) + 1;
`else
    return s + 1;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input alu_shift_op_e op, input logic [31:0] a, input logic [4:0] s);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.shamt = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'h5A5A_5A5A;
    bus.shamt = 5'd3;
    bus.op    = OP_SRA;
    @(negedge clk);
  endtask

  task automatic wait_done(input int e0, output int edges);
    edges = e0;
    while (!bus.done && edges < 200) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int e;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{OP_SLL,  32'h0000_0001, 5'd4,  32'h0000_0010};
    vecs[1]  = '{OP_SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2]  = '{OP_SRL,  32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[3]  = '{OP_SRL,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{OP_PASS, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF};
    vecs[5]  = '{OP_SLL,  32'h0000_00FF, 5'd8,  32'h0000_FF00};
    vecs[6]  = '{OP_SRA,  32'h8765_4321, 5'd4,  32'hF876_5432};
    vecs[7]  = '{OP_SRL,  32'h8765_4321, 5'd4,  32'h0876_5432};
    vecs[8]  = '{OP_SLL,  32'h8765_4321, 5'd31, 32'h8000_0000};
    vecs[9]  = '{OP_SRA,  32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[10] = '{OP_SLL,  32'h0000_0001, 5'd9,  32'h0000_0200};
    vecs[11] = '{OP_SRA,  32'h8000_0000, 5'd1,  32'hC000_0000};

    // Reset with a start request that would finish at once if accepted.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = OP_PASS;
    bus.a     = 32'hFFFF_FFFF;
    bus.shamt = 5'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", bus.result, 32'd0);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_done", 32'(bus.done), 32'd0);
    check("post_rst_result", bus.result, 32'd0);

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].shamt);
      wait_done(1, e);
      check($sformatf("v%0d_latency", i), 32'(e), 32'(exp_lat(vecs[i].op, int'(vecs[i].shamt))));
      check($sformatf("v%0d_result", i), bus.result, vecs[i].exp_result);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_result_hold", i), bus.result, vecs[i].exp_result);
    end

    // Start while busy is ignored.
    issue(OP_SLL, 32'h0000_00FF, 5'd8);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_SLL;
    bus.a     = 32'h0000_0000;
    bus.shamt = 5'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    wait_done(3, e);
    check("midbusy_latency", 32'(e), 32'(exp_lat(OP_SLL, 8)));
    check("midbusy_result", bus.result, 32'h0000_FF00);

    // Start in the DONE cycle is accepted back-to-back.
    issue(OP_SRL, 32'h0000_0010, 5'd4);
    check("b2b_done_low", 32'(bus.done), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done(1, e);
    check("b2b_latency", 32'(e), 32'(exp_lat(OP_SRL, 4)));
    check("b2b_result", bus.result, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);

    // Reset during the third shift cycle drops the operation.
    issue(OP_SLL, 32'h0000_0001, 5'd20);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) begin
        check("midrst_no_activity", {30'd0, bus.busy, bus.done}, 32'd0);
        break;
      end
    end
    check("midrst_result_idle", bus.result, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
